// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the Y86-64 execute-stage ALU slice: function codes,
// the default datapath width, the condition-code record with its reset value,
// and the occupancy state of the output register stage.
package alu_pkg;

  // Default operand/result width
  localparam int ALU_W = 64;

  // ALU function codes carried in the ifun field
  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;

  // Architectural condition codes
  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  // After reset, Y86 defines the condition codes as ZF set and SF/OF clear
  localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

  // Occupancy of the single-entry output register
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_core.sv
// alu_core
// Purely combinational ALU operator block. Computes ADD (b + a), SUB (b - a),
// AND and XOR on W-bit operands and derives ZF/SF/OF for the result.
// Ports:
//   ifun    - function code (0 ADD, 1 SUB, 2 AND, 3 XOR, others illegal)
//   a, b    - operands (valA / valB)
//   res     - result, forced to zero for an illegal function code
//   cc      - condition codes derived from res
//   illegal - high when ifun is not one of the four legal codes
module alu_core
  import alu_pkg::*;
#(
  parameter int W = ALU_W
) (
  input  logic [3:0]   ifun,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] res,
  output cc_t          cc,
  output logic         illegal
);

  logic [W-1:0] sum;
  logic [W-1:0] diff;

  // Carry-out is intentionally dropped: arithmetic is modulo 2^W
  assign sum  = b + a;
  assign diff = b - a;

  // Operator select and flag generation. Overflow follows the sign rules of
  // two's complement: ADD overflows when like-signed operands give a result
  // of the other sign; SUB (b - a) overflows when the operands differ in sign
  // and the result's sign differs from the minuend b.
  always_comb begin
    res     = '0;
    illegal = 1'b0;
    cc      = '0;
    unique case (ifun)
      ALU_ADD: begin
        res   = sum;
        cc.of = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
      end
      ALU_SUB: begin
        res   = diff;
        cc.of = (a[W-1] != b[W-1]) && (diff[W-1] != b[W-1]);
      end
      ALU_AND: res = a & b;
      ALU_XOR: res = a ^ b;
      default: illegal = 1'b1;
    endcase
    cc.zf = (res == '0);
    cc.sf = res[W-1];
  end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit
// Registered execute stage for the Y86-64 pipeline. Accepts one operation
// per cycle from decode over valid/ready, holds the result in a single-entry
// output register for memory/writeback, and owns the architectural condition
// code register.
// Ports:
//   clk, rst_n          - clock and asynchronous active-low reset
//   in_valid, in_ready  - upstream handshake (accept = in_valid && in_ready)
//   ifun, a, b          - operation and operands
//   set_cc              - load CC from this operation (legal ifun only)
//   out_valid, out_ready- downstream handshake
//   result, err         - registered result and illegal-ifun marker
//   zf, sf, of          - architectural condition codes
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int W = ALU_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   ifun,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         set_cc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         err,
  output logic         zf,
  output logic         sf,
  output logic         of
);

  state_t       state;
  state_t       state_next;
  logic         accept;
  logic [W-1:0] core_res;
  cc_t          core_cc;
  logic         core_illegal;
  cc_t          cc_q;

  alu_core #(.W(W)) u_core (
    .ifun    (ifun),
    .a       (a),
    .b       (b),
    .res     (core_res),
    .cc      (core_cc),
    .illegal (core_illegal)
  );

  assign accept = in_valid && in_ready;

  // Occupancy register; reset discards any held result at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_next;
  end

  // A drain with a simultaneous accept keeps the stage full
  always_comb begin
    state_next = state;
    unique case (state)
      ST_EMPTY: if (accept) state_next = ST_FULL;
      ST_FULL:  if (out_ready && !accept) state_next = ST_EMPTY;
      default:  state_next = ST_EMPTY;
    endcase
  end

  // Ready passes out_ready straight through so a full stage being drained
  // can take a new operation in the same cycle
  always_comb begin
    out_valid = (state == ST_FULL);
    in_ready  = (state != ST_FULL) || out_ready;
  end

  // Result register only moves on accept, which keeps it stable during stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      err    <= 1'b0;
    end else if (accept) begin
      result <= core_res;
      err    <= core_illegal;
    end
  end

  // CC loads together with the result so both become visible in the same
  // cycle; an illegal function never disturbs the architectural flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 cc_q <= CC_RESET;
    else if (accept && set_cc && !core_illegal) cc_q <= core_cc;
  end

  assign zf = cc_q.zf;
  assign sf = cc_q.sf;
  assign of = cc_q.of;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit
// Scoreboard bench for alu_exec_unit. The stimulus process predicts which
// operations are accepted from its own occupancy model and pushes the
// expected response; the monitor pops and compares on every output transfer.
module tb_alu_exec_unit;

  localparam int W = 64;

  typedef struct {
    logic [W-1:0] res;
    logic         err;
    logic         zf;
    logic         sf;
    logic         of;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   ifun;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         set_cc;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         err;
  logic         zf;
  logic         sf;
  logic         of;

  int   checks;
  int   errors;
  exp_t sb[$];
  logic modelFull;
  logic mZf;
  logic mSf;
  logic mOf;

  alu_exec_unit #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ifun      (ifun),
    .a         (a),
    .b         (b),
    .set_cc    (set_cc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .err       (err),
    .zf        (zf),
    .sf        (sf),
    .of        (of)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference behaviour: signed arithmetic on sign-extended operands gives
  // the wrapped result and overflow directly; CC is the bench's own copy.
  function automatic exp_t refOp(input logic [3:0] f, input logic [W-1:0] x,
                                 input logic [W-1:0] y, input logic sc);
    exp_t         e;
    logic [W:0]   ext;
    logic [W-1:0] r;
    logic         o;
    logic         legal;
    legal = 1'b1;
    r     = '0;
    o     = 1'b0;
    ext   = '0;
    case (f)
      4'h0: begin ext = {y[W-1], y} + {x[W-1], x}; r = ext[W-1:0]; o = ext[W] ^ ext[W-1]; end
      4'h1: begin ext = {y[W-1], y} - {x[W-1], x}; r = ext[W-1:0]; o = ext[W] ^ ext[W-1]; end
      4'h2: r = x & y;
      4'h3: r = x ^ y;
      default: legal = 1'b0;
    endcase
    if (legal && sc) begin
      mZf = (r == '0);
      mSf = r[W-1];
      mOf = o;
    end
    e.res = legal ? r : '0;
    e.err = !legal;
    e.zf  = mZf;
    e.sf  = mSf;
    e.of  = mOf;
    return e;
  endfunction

  // Drives one cycle of inputs after the falling edge, checks handshake
  // outputs against the occupancy model, and records accepted operations.
  task automatic applyStimulus(input logic v, input logic [3:0] f, input logic [W-1:0] x,
                               input logic [W-1:0] y, input logic sc, input logic ordy);
    logic expReady;
    logic acc;
    @(negedge clk);
    #1;
    in_valid  = v;
    ifun      = f;
    a         = x;
    b         = y;
    set_cc    = sc;
    out_ready = ordy;
    #1;
    expReady = !modelFull || ordy;
    checkOutput("in_ready", W'(in_ready), W'(expReady));
    checkOutput("out_valid", W'(out_valid), W'(modelFull));
    if (modelFull && !ordy && sb.size() > 0) checkOutput("stall_hold", result, sb[0].res);
    acc = v && expReady;
    if (acc) sb.push_back(refOp(f, x, y, sc));
    if (acc)                   modelFull = 1'b1;
    else if (modelFull && ordy) modelFull = 1'b0;
  endtask

  function automatic logic [W-1:0] pickOperand();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 64'h1;
      2: return 64'h7FFF_FFFF_FFFF_FFFF;
      3: return 64'h8000_0000_0000_0000;
      4: return '1;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  // Monitor: just before each rising edge, a valid output with ready high is
  // a completed transfer and must match the oldest expected response
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("spurious_output", W'(out_valid), '0);
        end else begin
          e = sb.pop_front();
          checkOutput("result", result, e.res);
          checkOutput("err", W'(err), W'(e.err));
          checkOutput("zf", W'(zf), W'(e.zf));
          checkOutput("sf", W'(sf), W'(e.sf));
          checkOutput("of", W'(of), W'(e.of));
        end
      end
    end
  end

  initial begin
    checks    = 0;
    errors    = 0;
    modelFull = 1'b0;
    mZf       = 1'b1;
    mSf       = 1'b0;
    mOf       = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    ifun      = 4'h0;
    a         = '0;
    b         = '0;
    set_cc    = 1'b0;
    out_ready = 1'b1;

    // Reset values
    repeat (2) @(negedge clk);
    checkOutput("rst_result", result, '0);
    checkOutput("rst_err", W'(err), '0);
    checkOutput("rst_zf", W'(zf), W'(1));
    checkOutput("rst_sf", W'(sf), '0);
    checkOutput("rst_of", W'(of), '0);
    #1;
    rst_n = 1'b1;

    // Directed operations from the plan
    applyStimulus(1'b1, 4'h3, 64'h26, 64'h31, 1'b1, 1'b1);
    applyStimulus(1'b1, 4'h0, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    applyStimulus(1'b1, 4'h1, 64'h5, 64'h5, 1'b1, 1'b1);
    applyStimulus(1'b1, 4'h2, 64'hF0, 64'h0F, 1'b0, 1'b1);
    applyStimulus(1'b1, 4'h9, 64'h12, 64'h34, 1'b1, 1'b1);
    applyStimulus(1'b0, 4'h0, '0, '0, 1'b0, 1'b1);

    // Backpressure: ops offered back to back while the consumer stalls
    applyStimulus(1'b1, 4'h0, 64'h10, 64'h20, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'h1, 64'h30, 64'h10, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'h1, 64'h30, 64'h10, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'h1, 64'h30, 64'h10, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'h1, 64'h30, 64'h10, 1'b1, 1'b1);
    applyStimulus(1'b1, 4'h3, 64'hFF, 64'h0F, 1'b1, 1'b1);
    applyStimulus(1'b0, 4'h0, '0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, 4'h0, '0, '0, 1'b0, 1'b1);

    // Reset while a result is held by a stalled consumer
    applyStimulus(1'b1, 4'h0, 64'h3, 64'h4, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'h0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", W'(out_valid), '0);
    checkOutput("midrst_zf", W'(zf), W'(1));
    checkOutput("midrst_result", result, '0);
    sb.delete();
    modelFull = 1'b0;
    mZf       = 1'b1;
    mSf       = 1'b0;
    mOf       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) applyStimulus(1'b0, 4'h0, '0, '0, 1'b0, 1'b1);

    // Randomized traffic with mixed backpressure and occasional illegal ops
    for (int i = 0; i < 400; i++) begin
      logic [3:0] f;
      f = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      applyStimulus(1'($urandom_range(0, 3) != 0), f, pickOperand(), pickOperand(),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0));
    end

    // Drain everything still in flight
    repeat (4) applyStimulus(1'b0, 4'h0, '0, '0, 1'b0, 1'b1);
    checkOutput("scoreboard_empty", W'(sb.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
